// File: rtl/mdu_pkg.sv
// mdu_pkg: shared opcode/state types and operand-signedness helpers for mdu_iter
package mdu_pkg;
  typedef enum logic [2:0] {
    OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU
  } mdu_op_e;
  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} mdu_state_e;
  function automatic logic is_div(mdu_op_e op);
    return op[2];
  endfunction
  function automatic logic is_signed_a(mdu_op_e op);
    return op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
  endfunction
  function automatic logic is_signed_b(mdu_op_e op);
    return op inside {OP_MULH, OP_DIV, OP_REM};
  endfunction
endpackage

// File: rtl/mdu_iter_cond_neg.sv
// cond_neg: two's-complement negate when neg is set, pass-through otherwise
module cond_neg #(
  parameter int W = 32
) (
  input  logic         neg,
  input  logic [W-1:0] in,
  output logic [W-1:0] out
);
  assign out = neg ? ~in + W'(1) : in;
endmodule

// File: rtl/mdu_iter.sv
// mdu_iter: radix-2 iterative RV32M multiply/divide unit with valid/ready handshakes
module mdu_iter
  import mdu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [2:0]      i_op,
  input  logic [XLEN-1:0] i_op_a,
  input  logic [XLEN-1:0] i_op_b,
  input  logic            i_flush,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [XLEN-1:0] o_result,
  output logic            o_busy
);
  localparam int CNT_W = $clog2(XLEN) + 1;
  mdu_state_e        state_q, state_d;
  mdu_op_e           op_q, op_d, in_op;
  logic              sa_q, sa_d, sb_q, sb_d, neg_a, neg_b, dz, ovf, fix_neg;
  logic [XLEN-1:0]   ma_q, ma_d, mb_q, mb_d, result_q, result_d;
  logic [XLEN-1:0]   abs_a, abs_b, fast_res, fix_res;
  logic [2*XLEN-1:0] acc_q, acc_d, fix_in, fix_out;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [XLEN:0]     mul_sum, div_r, div_diff;
  assign in_op    = mdu_op_e'(i_op);
  assign neg_a    = is_signed_a(in_op) & i_op_a[XLEN-1];
  assign neg_b    = is_signed_b(in_op) & i_op_b[XLEN-1];
  assign dz       = is_div(in_op) & ~|i_op_b;
  assign ovf      = (in_op == OP_DIV || in_op == OP_REM) &&
                    i_op_a == {1'b1, {(XLEN-1){1'b0}}} && &i_op_b;
  assign fast_res = dz ? (in_op[1] ? i_op_a : '1) : (in_op == OP_DIV ? i_op_a : '0);
  cond_neg #(.W(XLEN)) u_abs_a (.neg(neg_a), .in(i_op_a), .out(abs_a));
  cond_neg #(.W(XLEN)) u_abs_b (.neg(neg_b), .in(i_op_b), .out(abs_b));
  // Divide keeps remainder in the high half and quotient in the low half; the
  // product is negated at full width so MULH*/MUL both see a correct result.
  assign fix_in  = !is_div(op_q) ? acc_q :
                   {{XLEN{1'b0}}, op_q[1] ? acc_q[2*XLEN-1:XLEN] : acc_q[XLEN-1:0]};
  assign fix_neg = op_q == OP_REM ? sa_q : sa_q ^ sb_q;
  cond_neg #(.W(2*XLEN)) u_fix (.neg(fix_neg), .in(fix_in), .out(fix_out));
  assign fix_res = (op_q == OP_MUL || is_div(op_q)) ? fix_out[XLEN-1:0] : fix_out[2*XLEN-1:XLEN];
  // One shift-add multiply step and one restoring-divide step on the magnitudes
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (mb_q[0] ? {1'b0, ma_q} : '0);
    div_r    = {acc_q[2*XLEN-1:XLEN], ma_q[XLEN-1]};
    div_diff = div_r - {1'b0, mb_q};
  end
  // Next-state and datapath updates; flush overrides everything except reset
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    ma_d     = ma_q;
    mb_d     = mb_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    case (state_q)
      S_IDLE: if (i_valid && !i_flush) begin
        op_d    = in_op;
        sa_d    = neg_a;
        sb_d    = neg_b;
        ma_d    = abs_a;
        mb_d    = abs_b;
        acc_d   = '0;
        cnt_d   = CNT_W'(XLEN);
        state_d = (dz || ovf) ? S_DONE : S_CALC;
        if (dz || ovf) result_d = fast_res;
      end
      S_CALC: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (is_div(op_q)) begin
          ma_d  = ma_q << 1;
          acc_d = div_diff[XLEN] ? {div_r[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                                 : {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
        end else begin
          mb_d  = mb_q >> 1;
          acc_d = {mul_sum, acc_q[XLEN-1:1]};
        end
        if (cnt_q == CNT_W'(1)) state_d = S_FIX;
      end
      S_FIX: begin
        result_d = fix_res;
        state_d  = S_DONE;
      end
      S_DONE: if (i_ready) state_d = S_IDLE;
    endcase
    if (i_flush) state_d = S_IDLE;
  end
  // State and datapath registers with synchronous reset
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q  <= S_IDLE;
      op_q     <= OP_MUL;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      ma_q     <= '0;
      mb_q     <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      ma_q     <= ma_d;
      mb_q     <= mb_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end
  assign o_ready  = state_q == S_IDLE;
  assign o_valid  = state_q == S_DONE;
  assign o_busy   = state_q != S_IDLE;
  assign o_result = result_q;
endmodule
